// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_unit_pkg : shared types and constants for the fetch stage  |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_fifo : ring buffer of {pc, inst} entries toward decode     |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output fetch_entry_t               o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, a push lands in the slot being popped this cycle.
            if (i_push) begin
                mem_d[wr_ptr_q] = i_push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(i_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_unit : RV32 fetch stage, one outstanding imem read         |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_id_ready,
    output logic        o_id_valid,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    // Gated by reset so no request is visible while the core is held.
    assign o_imem_req  = i_rst_n && (state_q == FS_REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign o_imem_addr = word_align(pc_q);

    assign o_id_valid  = !fifo_empty;
    assign o_id_inst   = fifo_empty ? NOP_INST : fifo_head.inst;
    assign o_id_pc     = fifo_empty ? 32'h0    : fifo_head.pc;

    assign fifo_pop    = o_id_valid && i_id_ready && !i_redirect;
    assign push_entry  = '{pc: inflight_pc_q, inst: i_imem_rdata};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        fifo_push     = 1'b0;

        unique case (state_q)
            FS_REQ: begin
                if (o_imem_req && i_imem_gnt) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (i_imem_rvalid) begin
                    fifo_push = !fifo_full || fifo_pop;
                    state_d   = FS_REQ;
                end
            end
            FS_DROP: begin
                if (i_imem_rvalid) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // A redirect makes any in-flight or just-granted read stale.
        if (i_redirect) begin
            pc_d      = word_align(i_redirect_pc);
            fifo_push = 1'b0;
            unique case (state_q)
                FS_REQ:  state_d = (o_imem_req && i_imem_gnt) ? FS_DROP : FS_REQ;
                FS_WAIT: state_d = i_imem_rvalid ? FS_REQ : FS_DROP;
                FS_DROP: state_d = i_imem_rvalid ? FS_REQ : FS_DROP;
                default: state_d = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= FS_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (fifo_push),
        .i_push_entry (push_entry),
        .i_pop        (fifo_pop),
        .i_flush      (i_redirect),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty),
        .o_count      (fifo_count),
        .o_head       (fifo_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_fetch_unit : table, directed and random checks of fetch_unit  |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (rpc),
        .i_id_ready    (ready),
        .o_id_valid    (id_valid),
        .o_id_inst     (id_inst),
        .o_id_pc       (id_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus controls set by the test sequences.
    bit          b_ready = 1'b0;
    bit          b_redirect = 1'b0;
    logic [31:0] b_rpc = 32'h0;
    int          gnt_pct = 100;
    int          lat_fixed = 1;

    // Memory responder state.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    // Transaction-level reference: fetched-but-undelivered words and next PC.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_out_pc = 32'h0;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    bit          s_gnt, s_rvalid;
    bit          watch8 = 1'b0;
    int          seen8 = 0;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        m_pc     = RST_PC;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = 32'h0;
        redirect = 1'b0;
    endtask

    task automatic cycle();
        bit          e_valid;
        logic [31:0] e_pc, e_inst;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = id_valid;
        s_pc    = id_pc;
        s_inst  = id_inst;
        e_valid = (q_pc.size() > 0);
        e_pc    = e_valid ? q_pc[0] : 32'h0;
        e_inst  = e_valid ? q_inst[0] : NOP_INST;
        chk("imem_req", 32'(s_req), 32'(!m_out && (q_pc.size() < DEPTH)));
        chk("imem_addr", s_addr, m_pc);
        chk("id_valid", 32'(s_valid), 32'(e_valid));
        chk("id_pc", s_pc, e_pc);
        chk("id_inst", s_inst, e_inst);
        if (watch8 && s_valid && s_pc == 32'h8) seen8++;

        ready    = b_ready;
        redirect = b_redirect;
        rpc      = b_rpc;
        gnt      = s_req && ($urandom_range(0, 99) < gnt_pct);
        rvalid   = 1'b0;
        rdata    = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = inst_of(mem_addr);
            end
        end
        s_gnt    = gnt;
        s_rvalid = rvalid;

        @(posedge clk);
        if (redirect) begin
            q_pc.delete();
            q_inst.delete();
            if (rvalid) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (m_out) m_stale = 1'b1;
            if (gnt) begin
                m_out   = 1'b1;
                m_stale = 1'b1;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (e_valid && ready) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (rvalid) begin
                if (!m_stale) begin
                    q_pc.push_back(m_out_pc);
                    q_inst.push_back(rdata);
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (gnt) begin
                m_out    = 1'b1;
                m_stale  = 1'b0;
                m_out_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
        if (rvalid) mem_busy = 1'b0;
        if (gnt) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_inst", id_inst, NOP_INST);
        chk("rst_pc", id_pc, 32'h0);
        model_reset();
        b_redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bit found;

        tbl[0]  = '{1, 1, 1, 32'h0, 0, 32'h0};
        tbl[1]  = '{0, 1, 0, 32'h4, 0, 32'h0};
        tbl[2]  = '{0, 1, 1, 32'h4, 1, 32'h0};
        tbl[3]  = '{0, 1, 0, 32'h8, 0, 32'h0};
        tbl[4]  = '{0, 1, 1, 32'h8, 1, 32'h4};
        tbl[5]  = '{0, 1, 0, 32'hC, 0, 32'h0};
        tbl[6]  = '{0, 1, 1, 32'hC, 1, 32'h8};
        tbl[7]  = '{1, 0, 1, 32'h0, 0, 32'h0};
        tbl[8]  = '{0, 0, 0, 32'h4, 0, 32'h0};
        tbl[9]  = '{0, 0, 1, 32'h4, 1, 32'h0};
        tbl[10] = '{0, 0, 0, 32'h8, 1, 32'h0};
        tbl[11] = '{0, 0, 0, 32'h8, 1, 32'h0};
        tbl[12] = '{0, 0, 0, 32'h8, 1, 32'h0};
        tbl[13] = '{0, 1, 0, 32'h8, 1, 32'h0};
        tbl[14] = '{0, 1, 1, 32'h8, 1, 32'h4};

        gnt_pct   = 100;
        lat_fixed = 1;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) apply_reset();
            b_ready = tbl[i].rdy;
            cycle();
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
        end

        // Redirect while waiting on the read of 8, memory latency 3.
        apply_reset();
        lat_fixed = 3;
        b_ready   = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (s_gnt && s_addr == 32'h8) found = 1'b1;
        end
        chk("timeout_gnt8", 32'(found), 32'h1);
        watch8     = 1'b1;
        seen8      = 0;
        b_redirect = 1'b1;
        b_rpc      = 32'h100;
        cycle();
        b_redirect = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_req) found = 1'b1;
        end
        chk("timeout_req_after_redir", 32'(found), 32'h1);
        chk("redir_wait_addr", s_addr, 32'h100);
        repeat (10) cycle();
        chk("pc8_presented", seen8, 0);
        watch8 = 1'b0;

        // Redirect in the same cycle as read data returns.
        apply_reset();
        lat_fixed = 1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (mem_busy && mem_cnt == 1) found = 1'b1;
        end
        chk("timeout_rv_align", 32'(found), 32'h1);
        b_redirect = 1'b1;
        b_rpc      = 32'h200;
        cycle();
        chk("redir_rv_aligned", 32'(s_rvalid), 32'h1);
        b_redirect = 1'b0;
        cycle();
        chk("redir_rv_req", 32'(s_req), 32'h1);
        chk("redir_rv_addr", s_addr, 32'h200);
        chk("redir_rv_valid", 32'(s_valid), 32'h0);

        // Unaligned redirect target, then PC wrap at the top of memory.
        b_redirect = 1'b1;
        b_rpc      = 32'h103;
        cycle();
        b_redirect = 1'b0;
        cycle();
        chk("unaligned_addr", s_addr, 32'h100);
        repeat (4) cycle();
        b_redirect = 1'b1;
        b_rpc      = 32'hFFFF_FFFC;
        cycle();
        b_redirect = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_gnt && s_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk("timeout_gnt_top", 32'(found), 32'h1);
        cycle();
        chk("wrap_addr", s_addr, 32'h0);
        repeat (6) cycle();

        // Reset with a full buffer, and reset while dropping a stale read.
        apply_reset();
        b_ready = 1'b0;
        repeat (6) cycle();
        chk("full_req", 32'(s_req), 32'h0);
        chk("full_valid", 32'(s_valid), 32'h1);
        apply_reset();
        b_ready = 1'b1;
        cycle();
        chk("post_rst_full_req", 32'(s_req), 32'h1);
        chk("post_rst_full_addr", s_addr, RST_PC);
        lat_fixed = 5;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_gnt) found = 1'b1;
        end
        chk("timeout_gnt_drop", 32'(found), 32'h1);
        b_redirect = 1'b1;
        b_rpc      = 32'h40;
        cycle();
        b_redirect = 1'b0;
        cycle();
        chk("drop_req", 32'(s_req), 32'h0);
        apply_reset();
        cycle();
        chk("post_rst_drop_req", 32'(s_req), 32'h1);
        chk("post_rst_drop_addr", s_addr, RST_PC);
        repeat (10) cycle();

        // Randomized traffic against the reference.
        apply_reset();
        gnt_pct   = 60;
        lat_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            b_ready    = ($urandom_range(0, 9) < 7);
            b_redirect = ($urandom_range(0, 19) == 0);
            b_rpc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_0FFF);
            cycle();
        end
        b_redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
